// File: rtl/tdm_demux4_if.sv
// rtl/tdm_demux4_if.sv - shared-link word stream in, parallel channel words out
interface tdm_demux4_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_sof;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] out_A;
  logic [WIDTH-1:0] out_B;
  logic [WIDTH-1:0] out_C;
  logic [WIDTH-1:0] out_D;
  logic             frame_valid;
  logic             sync_err;
  logic [1:0]       slot;

  modport master (
    output in_valid, in_sof, in_data,
    input  out_A, out_B, out_C, out_D, frame_valid, sync_err, slot
  );

  modport slave (
    input  in_valid, in_sof, in_data,
    output out_A, out_B, out_C, out_D, frame_valid, sync_err, slot
  );
endinterface

// File: rtl/tdm_demux4.sv
// rtl/tdm_demux4.sv - 4-slot TDM receiver: slot tracking, staging, framed parallel output
module tdm_demux4 #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  tdm_demux4_if.slave  bus
);
  typedef enum logic {HUNT, RECV} state_t;

  state_t           state_q;
  logic [1:0]       slot_q;
  logic [WIDTH-1:0] stage_a_q, stage_b_q, stage_c_q;
  logic [WIDTH-1:0] out_a_q, out_b_q, out_c_q, out_d_q;
  logic             frame_valid_q;
  logic             sync_err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= HUNT;
      slot_q        <= 2'd0;
      stage_a_q     <= '0;
      stage_b_q     <= '0;
      stage_c_q     <= '0;
      out_a_q       <= '0;
      out_b_q       <= '0;
      out_c_q       <= '0;
      out_d_q       <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      if (bus.in_valid) begin
        unique case (state_q)
          HUNT: begin
            if (bus.in_sof) begin
              stage_a_q <= bus.in_data;
              slot_q    <= 2'd1;
              state_q   <= RECV;
            end else begin
              sync_err_q <= 1'b1;
            end
          end
          RECV: begin
            // An early SOF abandons the partial frame and restarts it at slot 0.
            if (bus.in_sof) begin
              sync_err_q <= 1'b1;
              stage_a_q  <= bus.in_data;
              slot_q     <= 2'd1;
            end else begin
              unique case (slot_q)
                2'd1: begin
                  stage_b_q <= bus.in_data;
                  slot_q    <= 2'd2;
                end
                2'd2: begin
                  stage_c_q <= bus.in_data;
                  slot_q    <= 2'd3;
                end
                default: begin
                  out_a_q       <= stage_a_q;
                  out_b_q       <= stage_b_q;
                  out_c_q       <= stage_c_q;
                  out_d_q       <= bus.in_data;
                  frame_valid_q <= 1'b1;
                  slot_q        <= 2'd0;
                  state_q       <= HUNT;
                end
              endcase
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign bus.out_A       = out_a_q;
  assign bus.out_B       = out_b_q;
  assign bus.out_C       = out_c_q;
  assign bus.out_D       = out_d_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.sync_err    = sync_err_q;
  assign bus.slot        = slot_q;
endmodule

// File: tb/tb_tdm_demux4.sv
// tb/tb_tdm_demux4.sv - directed self-checking bench for tdm_demux4
module tb_tdm_demux4;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   fv_cnt;
  int   se_cnt;

  tdm_demux4_if #(.WIDTH(8)) bus ();

  tdm_demux4 #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle: drive at negedge, sample 1 time unit after the rising edge.
  task automatic cycle(input logic v, input logic sof, input logic [7:0] d);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_sof   = sof;
    bus.in_data  = d;
    @(posedge clk);
    #1;
    if (bus.frame_valid) fv_cnt++;
    if (bus.sync_err) se_cnt++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_data  = 8'h00;
    reset        = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    fv_cnt = 0;
    se_cnt = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if ({bus.out_A, bus.out_B, bus.out_C, bus.out_D} !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outs: got %h want 00000000", {bus.out_A, bus.out_B, bus.out_C, bus.out_D});
    end
    n_checks++;
    if ({bus.frame_valid, bus.sync_err, bus.slot} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got fv=%b se=%b slot=%0d want 0/0/0", bus.frame_valid, bus.sync_err, bus.slot);
    end
  endtask

  task automatic test_basic_frame();
    do_reset();
    cycle(1, 1, 8'h11);
    cycle(1, 0, 8'h22);
    cycle(1, 0, 8'h33);
    n_checks++;
    if (bus.frame_valid !== 1'b0 || bus.out_A !== 8'h00 || bus.slot !== 2'd3) begin
      n_fail++;
      $display("FAIL basic_pre: got fv=%b outA=%h slot=%0d want 0/00/3", bus.frame_valid, bus.out_A, bus.slot);
    end
    cycle(1, 0, 8'h44);
    n_checks++;
    if ({bus.out_A, bus.out_B, bus.out_C, bus.out_D} !== 32'h11223344) begin
      n_fail++;
      $display("FAIL basic_outs: got %h want 11223344", {bus.out_A, bus.out_B, bus.out_C, bus.out_D});
    end
    n_checks++;
    if (bus.frame_valid !== 1'b1 || bus.sync_err !== 1'b0 || bus.slot !== 2'd0) begin
      n_fail++;
      $display("FAIL basic_flags: got fv=%b se=%b slot=%0d want 1/0/0", bus.frame_valid, bus.sync_err, bus.slot);
    end
    cycle(0, 0, 8'h00);
    n_checks++;
    if (bus.frame_valid !== 1'b0 || fv_cnt != 1) begin
      n_fail++;
      $display("FAIL basic_pulse: got fv=%b count=%0d want 0/1", bus.frame_valid, fv_cnt);
    end
  endtask

  task automatic test_gaps();
    do_reset();
    cycle(1, 1, 8'h11);
    cycle(1, 0, 8'h22);
    repeat (2) cycle(0, 0, 8'hEE);
    cycle(1, 0, 8'h33);
    repeat (5) cycle(0, 1, 8'hEE);
    n_checks++;
    if (fv_cnt != 0 || se_cnt != 0 || bus.slot !== 2'd3) begin
      n_fail++;
      $display("FAIL gaps_hold: got fv_cnt=%0d se_cnt=%0d slot=%0d want 0/0/3", fv_cnt, se_cnt, bus.slot);
    end
    cycle(1, 0, 8'h44);
    n_checks++;
    if ({bus.out_A, bus.out_B, bus.out_C, bus.out_D} !== 32'h11223344 || bus.frame_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL gaps_outs: got %h fv=%b want 11223344 fv=1", {bus.out_A, bus.out_B, bus.out_C, bus.out_D}, bus.frame_valid);
    end
    cycle(0, 0, 8'h00);
    n_checks++;
    if (fv_cnt != 1) begin
      n_fail++;
      $display("FAIL gaps_count: got %0d want 1", fv_cnt);
    end
  endtask

  task automatic test_early_sof();
    fv_cnt = 0;
    se_cnt = 0;
    cycle(1, 1, 8'hA0);
    cycle(1, 0, 8'hA1);
    cycle(1, 1, 8'hB0);
    n_checks++;
    if (bus.sync_err !== 1'b1 || bus.frame_valid !== 1'b0 || bus.slot !== 2'd1) begin
      n_fail++;
      $display("FAIL early_err: got se=%b fv=%b slot=%0d want 1/0/1", bus.sync_err, bus.frame_valid, bus.slot);
    end
    cycle(1, 0, 8'hB1);
    cycle(1, 0, 8'hB2);
    n_checks++;
    if ({bus.out_A, bus.out_B, bus.out_C, bus.out_D} !== 32'h11223344) begin
      n_fail++;
      $display("FAIL early_hold: got %h want 11223344", {bus.out_A, bus.out_B, bus.out_C, bus.out_D});
    end
    cycle(1, 0, 8'hB3);
    n_checks++;
    if ({bus.out_A, bus.out_B, bus.out_C, bus.out_D} !== 32'hB0B1B2B3 || bus.frame_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL early_outs: got %h fv=%b want b0b1b2b3 fv=1", {bus.out_A, bus.out_B, bus.out_C, bus.out_D}, bus.frame_valid);
    end
    n_checks++;
    if (fv_cnt != 1 || se_cnt != 1) begin
      n_fail++;
      $display("FAIL early_counts: got fv=%0d se=%0d want 1/1", fv_cnt, se_cnt);
    end
  endtask

  task automatic test_hunt_drop();
    do_reset();
    cycle(1, 0, 8'h55);
    n_checks++;
    if (bus.sync_err !== 1'b1 || bus.slot !== 2'd0) begin
      n_fail++;
      $display("FAIL hunt_err: got se=%b slot=%0d want 1/0", bus.sync_err, bus.slot);
    end
    cycle(1, 0, 8'h66);
    cycle(1, 1, 8'h01);
    cycle(1, 0, 8'h02);
    cycle(1, 0, 8'h03);
    n_checks++;
    if (fv_cnt != 0 || bus.out_A !== 8'h00) begin
      n_fail++;
      $display("FAIL hunt_nofv: got fv_cnt=%0d outA=%h want 0/00", fv_cnt, bus.out_A);
    end
    cycle(1, 0, 8'h04);
    n_checks++;
    if ({bus.out_A, bus.out_B, bus.out_C, bus.out_D} !== 32'h01020304 || fv_cnt != 1 || se_cnt != 2) begin
      n_fail++;
      $display("FAIL hunt_outs: got %h fv_cnt=%0d se_cnt=%0d want 01020304/1/2",
               {bus.out_A, bus.out_B, bus.out_C, bus.out_D}, fv_cnt, se_cnt);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cycle(1, 1, 8'h10);
    cycle(1, 0, 8'h11);
    cycle(1, 0, 8'h12);
    cycle(1, 0, 8'h13);
    n_checks++;
    if ({bus.out_A, bus.out_B, bus.out_C, bus.out_D} !== 32'h10111213 || bus.frame_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first: got %h fv=%b want 10111213 fv=1", {bus.out_A, bus.out_B, bus.out_C, bus.out_D}, bus.frame_valid);
    end
    cycle(1, 1, 8'h20);
    n_checks++;
    if (bus.frame_valid !== 1'b0 || bus.sync_err !== 1'b0 || bus.slot !== 2'd1) begin
      n_fail++;
      $display("FAIL b2b_sof: got fv=%b se=%b slot=%0d want 0/0/1", bus.frame_valid, bus.sync_err, bus.slot);
    end
    cycle(1, 0, 8'h21);
    cycle(1, 0, 8'h22);
    cycle(1, 0, 8'h23);
    n_checks++;
    if ({bus.out_A, bus.out_B, bus.out_C, bus.out_D} !== 32'h20212223 || bus.frame_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second: got %h fv=%b want 20212223 fv=1", {bus.out_A, bus.out_B, bus.out_C, bus.out_D}, bus.frame_valid);
    end
    n_checks++;
    if (fv_cnt != 2 || se_cnt != 0) begin
      n_fail++;
      $display("FAIL b2b_counts: got fv=%0d se=%0d want 2/0", fv_cnt, se_cnt);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    cycle(1, 1, 8'h11);
    cycle(1, 0, 8'h22);
    cycle(1, 0, 8'h33);
    cycle(1, 0, 8'h44);
    cycle(1, 1, 8'h50);
    cycle(1, 0, 8'h51);
    cycle(1, 0, 8'h52);
    n_checks++;
    if (bus.out_A !== 8'h11 || bus.slot !== 2'd3) begin
      n_fail++;
      $display("FAIL areset_pre: got outA=%h slot=%0d want 11/3", bus.out_A, bus.slot);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.out_A, bus.out_B, bus.out_C, bus.out_D} !== 32'h0 || bus.slot !== 2'd0 || bus.frame_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_now: got %h slot=%0d fv=%b want 00000000/0/0",
               {bus.out_A, bus.out_B, bus.out_C, bus.out_D}, bus.slot, bus.frame_valid);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    reset  = 1'b0;
    fv_cnt = 0;
    se_cnt = 0;
    cycle(1, 1, 8'h7A);
    cycle(1, 0, 8'h7B);
    cycle(1, 0, 8'h7C);
    cycle(1, 0, 8'h7D);
    n_checks++;
    if ({bus.out_A, bus.out_B, bus.out_C, bus.out_D} !== 32'h7A7B7C7D || fv_cnt != 1 || se_cnt != 0) begin
      n_fail++;
      $display("FAIL areset_after: got %h fv_cnt=%0d se_cnt=%0d want 7a7b7c7d/1/0",
               {bus.out_A, bus.out_B, bus.out_C, bus.out_D}, fv_cnt, se_cnt);
    end
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    fv_cnt       = 0;
    se_cnt       = 0;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_data  = 8'h00;
    test_reset();
    test_basic_frame();
    test_gaps();
    test_early_sof();
    test_hunt_drop();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Receive end of a 4-channel time-division-multiplexed word stream. A transmitter selects channels A, B, C and D in turn with a 4:1 select and sends them over one shared data bus.
- This block tracks slot position against a start-of-frame marker and buffers slots A–C in staging registers.
- It presents all four channel words together on parallel outputs, with a one-cycle frame strobe.
- It detects framing errors.
- It sits between the shared link and per-channel consumers.

Parameters:
- WIDTH, 8, bit width of each channel word.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data/in_sof are presented this cycle; always accepted, no backpressure.
- in_sof  input  1  start of frame; qualified by in_valid; marks the slot-0 (channel A) word.
- in_data  input  WIDTH  channel word for the current slot.
- out_A  output  WIDTH  channel A word of the last complete frame.
- out_B  output  WIDTH  channel B word of the last complete frame.
- out_C  output  WIDTH  channel C word of the last complete frame.
- out_D  output  WIDTH  channel D word of the last complete frame.
- frame_valid  output  1  one-cycle pulse: out_A..out_D were just updated.
- sync_err  output  1  one-cycle pulse: framing error detected.
- slot  output  2  next expected slot index (0 = A … 3 = D).

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high, named reset.
- While reset is high:
  - state is HUNT, slot is 0, staging registers are 0.
  - out_A..out_D are 0; frame_valid and sync_err are 0.
- Reset asserted mid-frame discards the partial frame; outputs clear immediately (asynchronous).
- All outputs are registered. frame_valid, sync_err and out_* change only on the clk edge after the accepting cycle, except on reset.
- A cycle with in_valid = 0 changes no state. Gaps of any length are allowed anywhere within a frame. frame_valid and sync_err are 0 in a gap cycle.
- State HUNT (slot = 0):
  - in_valid & in_sof: stage_A <= in_data; slot <= 1; go to RECV.
  - in_valid & !in_sof: word dropped; sync_err pulses; stay in HUNT.
- State RECV (slot is 1, 2 or 3):
  - in_valid & !in_sof & slot = 1: stage_B <= in_data; slot <= 2.
  - in_valid & !in_sof & slot = 2: stage_C <= in_data; slot <= 3.
  - in_valid & !in_sof & slot = 3 (frame completes):
    - out_A <= stage_A, out_B <= stage_B, out_C <= stage_C, out_D <= in_data, all in the same edge.
    - frame_valid pulses; slot <= 0; go to HUNT.
  - in_valid & in_sof (any slot in RECV): early SOF.
    - sync_err pulses; the partial frame is abandoned; out_* are unchanged.
    - This word is taken as a new slot 0: stage_A <= in_data; slot <= 1; stay in RECV.
- Back-to-back frames: after completion, the next valid word must carry in_sof. A slot-0 SOF word on the cycle immediately after slot 3 is accepted with no bubble.
- Latency: frame_valid and the new out_* appear on the edge at the end of the cycle in which the slot-3 word is accepted.
- frame_valid and sync_err are never high in the same cycle.
- out_* hold their value until the next complete frame or reset. Staging contents are never visible on out_* until a frame completes.
- slot wraps 3 -> 0 only through frame completion. Slot values outside 0–3 are unreachable.

Test Plan:
1. Reset, then 4 consecutive valid words with in_sof on the first: 0x11, 0x22, 0x33, 0x44.
   -> Edge after 0x44: out_A..D = 0x11/0x22/0x33/0x44, frame_valid high exactly 1 cycle, sync_err 0, slot 0.
2. Same frame with in_valid = 0 gaps of 0, 2 and 5 cycles between words.
   -> Identical outputs; frame_valid pulses once, only after the 4th valid word.
3. After a good frame (0x11..0x44): SOF 0xA0, 0xA1, then SOF 0xB0, 0xB1, 0xB2, 0xB3.
   -> sync_err pulses once at the second SOF; out_* stay 0x11..0x44 until completion; then out_A..D = 0xB0..0xB3 with one frame_valid.
4. Out of reset, non-SOF words 0x55, 0x66, then a full frame 0x01..0x04.
   -> Two sync_err pulses; no frame_valid until the frame completes; then out_A..D = 0x01..0x04.
5. Two back-to-back frames with no gap: 0x10..0x13, then 0x20..0x23.
   -> frame_valid pulses after 0x13 and after 0x23; final out_A..D = 0x20..0x23; no sync_err.
6. Reset asserted mid-cycle, between clock edges, after slot 2 of a frame with out_* holding 0x11..0x44.
   -> out_* = 0 and slot = 0 immediately. A following full frame 0x7A..0x7D completes normally.
